// File: rtl/frame_arb_pkg.sv
// Shared constants and types for the frame-buffer read arbiter.
// Frame geometry and the default BRAM timing used by the QR front-end.
package frame_arb_pkg;

  localparam int unsigned FRAME_WIDTH       = 32'd480;
  localparam int unsigned FRAME_HEIGHT      = 32'd480;
  localparam int unsigned FRAME_ADDR_W      = 32'd20;
  localparam int unsigned BRAM_READ_LATENCY = 32'd2;

  typedef logic [FRAME_ADDR_W-1:0] frame_addr_t;

  // Round-robin successor of idx among n requesters.
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    int unsigned nxt;
    nxt = idx + 32'd1;
    return (nxt >= n) ? 32'd0 : nxt;
  endfunction

endpackage

// File: rtl/frame_arb_rr_pick.sv
// Combinational round-robin picker: rotate requests by ptr, take the lowest set bit,
// then rotate the winning position back to an absolute index.
module frame_arb_rr_pick #(
  parameter int unsigned N     = 32'd3,
  parameter int unsigned IDX_W = (N > 32'd1) ? $clog2(N) : 32'd1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  logic [2*N-1:0]   dbl_s;
  logic [N-1:0]     rot_s;
  logic [IDX_W-1:0] off_s;
  logic             found_s;
  logic [IDX_W:0]   sum_s;

  // Rotate, priority-encode, unrotate.
  always_comb begin
    dbl_s   = {req, req} >> ptr;
    rot_s   = dbl_s[N-1:0];
    off_s   = '0;
    found_s = 1'b0;
    for (int p = 0; p < int'(N); p++) begin
      off_s   = (rot_s[p] && !found_s) ? IDX_W'(p) : off_s;
      found_s = found_s | rot_s[p];
    end
    sum_s = {1'b0, ptr} + {1'b0, off_s};
    if (!found_s) begin
      idx = '0;
    end else if (sum_s >= (IDX_W+1)'(N)) begin
      idx = IDX_W'(sum_s - (IDX_W+1)'(N));
    end else begin
      idx = sum_s[IDX_W-1:0];
    end
    gnt = found_s ? (N'(1) << idx) : '0;
    any = found_s;
  end

endmodule

// File: rtl/frame_read_arbiter.sv
// Round-robin arbiter sharing the frame BRAM read port, with owner-tagged responses.
// Optional port locking is enabled by defining FRAME_ARB_LOCK_EN.
module frame_read_arbiter
  import frame_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ      = 32'd3,
  parameter int unsigned ADDR_W       = FRAME_ADDR_W,
  parameter int unsigned PIX_W        = 32'd1,
  parameter int unsigned READ_LATENCY = BRAM_READ_LATENCY
) (
  input  logic                                   clk_in,
  input  logic                                   rst_in,
  input  logic [NUM_REQ-1:0]                     req_valid,
  input  logic [NUM_REQ-1:0][ADDR_W-1:0]         req_addr,
`ifdef FRAME_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]                     req_lock,
`endif
  output logic [NUM_REQ-1:0]                     req_ready,
  output logic [NUM_REQ-1:0]                     rsp_valid,
  output logic [PIX_W-1:0]                       rsp_pixel,
  output logic [ADDR_W-1:0]                      bram_addr,
  input  logic [PIX_W-1:0]                       bram_dout,
  output logic [$clog2(READ_LATENCY+1)-1:0]      inflight
);

  localparam int unsigned IDX_W = (NUM_REQ > 32'd1) ? $clog2(NUM_REQ) : 32'd1;
  localparam int unsigned CNT_W = $clog2(READ_LATENCY + 32'd1);

  logic [IDX_W-1:0]   rr_ptr_r;
  logic [IDX_W-1:0]   ptr_nxt_s;
  logic [NUM_REQ-1:0] elig_s;
  logic [NUM_REQ-1:0] gnt_s;
  logic [IDX_W-1:0]   win_s;
  logic               any_s;
  logic [NUM_REQ-1:0] own_last_s;
  logic [NUM_REQ-1:0] rsp_valid_r;
  logic [PIX_W-1:0]   rsp_pixel_r;
  logic [CNT_W-1:0]   inflight_r;

`ifdef FRAME_ARB_LOCK_EN
  logic             lock_act_r;
  logic [IDX_W-1:0] lock_own_r;
  logic             lock_rel_s;

  // Eligibility: a held lock masks everyone but its owner.
  always_comb begin
    if (lock_act_r) begin
      elig_s = req_valid & (NUM_REQ'(1) << lock_own_r) & ~{NUM_REQ{rst_in}};
    end else begin
      elig_s = req_valid & ~{NUM_REQ{rst_in}};
    end
    lock_rel_s = lock_act_r & ~req_lock[lock_own_r];
  end

  // Next pointer: frozen under lock, jumps past the owner on release.
  always_comb begin
    if (lock_rel_s) begin
      ptr_nxt_s = IDX_W'(rr_next(32'(lock_own_r), NUM_REQ));
    end else if (lock_act_r) begin
      ptr_nxt_s = rr_ptr_r;
    end else if (any_s) begin
      ptr_nxt_s = IDX_W'(rr_next(32'(win_s), NUM_REQ));
    end else begin
      ptr_nxt_s = rr_ptr_r;
    end
  end

  // Lock ownership state.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      lock_act_r <= 1'b0;
      lock_own_r <= '0;
    end else if (lock_act_r) begin
      lock_act_r <= ~lock_rel_s;
      lock_own_r <= lock_own_r;
    end else if (any_s && req_lock[win_s]) begin
      lock_act_r <= 1'b1;
      lock_own_r <= win_s;
    end else begin
      lock_act_r <= lock_act_r;
      lock_own_r <= lock_own_r;
    end
  end
`else
  // Eligibility and next pointer for plain round-robin.
  always_comb begin
    elig_s = req_valid & ~{NUM_REQ{rst_in}};
    if (any_s) begin
      ptr_nxt_s = IDX_W'(rr_next(32'(win_s), NUM_REQ));
    end else begin
      ptr_nxt_s = rr_ptr_r;
    end
  end
`endif

  frame_arb_rr_pick #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req (elig_s),
    .ptr (rr_ptr_r),
    .gnt (gnt_s),
    .idx (win_s),
    .any (any_s)
  );

  // Grant and BRAM address are combinational so acceptance costs no cycle.
  always_comb begin
    req_ready = gnt_s;
    if (any_s) begin
      bram_addr = req_addr[win_s];
    end else begin
      bram_addr = '0;
    end
  end

  // Round-robin pointer register.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      rr_ptr_r <= '0;
    end else begin
      rr_ptr_r <= ptr_nxt_s;
    end
  end

  // Owner tags travel alongside the BRAM pipeline; the output register is the last stage.
  if (READ_LATENCY > 32'd1) begin : g_pipe
    logic [READ_LATENCY-2:0][NUM_REQ-1:0] own_pipe_r;

    // Owner shift register.
    always_ff @(posedge clk_in) begin
      if (rst_in) begin
        own_pipe_r <= '0;
      end else begin
        own_pipe_r[0] <= gnt_s;
        for (int k = 1; k < int'(READ_LATENCY) - 1; k++) begin
          own_pipe_r[k] <= own_pipe_r[k-1];
        end
      end
    end
    assign own_last_s = own_pipe_r[READ_LATENCY-2];
  end else begin : g_nopipe
    assign own_last_s = gnt_s;
  end

  // Response register and in-flight counter.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      rsp_valid_r <= '0;
      rsp_pixel_r <= '0;
      inflight_r  <= '0;
    end else begin
      rsp_valid_r <= own_last_s;
      rsp_pixel_r <= bram_dout;
      case ({any_s, |rsp_valid_r})
        2'b10:   inflight_r <= inflight_r + CNT_W'(1);
        2'b01:   inflight_r <= inflight_r - CNT_W'(1);
        default: inflight_r <= inflight_r;
      endcase
    end
  end

  assign rsp_valid = rsp_valid_r;
  assign rsp_pixel = rsp_pixel_r;
  assign inflight  = inflight_r;

endmodule

// File: tb/tb_frame_read_arbiter.sv
// Scoreboard bench for frame_read_arbiter: directed grant vectors plus a random phase;
// responses are checked by an independent monitor. Lock test runs with FRAME_ARB_LOCK_EN.
module tb_frame_read_arbiter;
  import frame_arb_pkg::*;

  localparam int AW = FRAME_ADDR_W;

  logic              clk_in = 1'b0;
  logic              rst_in;
  logic [2:0]        req_valid;
  logic [2:0][AW-1:0] req_addr;
  logic [2:0]        req_lock;
  logic [2:0]        req_ready;
  logic [2:0]        rsp_valid;
  logic [0:0]        rsp_pixel;
  logic [AW-1:0]     bram_addr;
  logic [0:0]        bram_dout;
  logic [1:0]        inflight;

  typedef struct {
    int   idx;
    logic pix;
    int   due;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;

  frame_read_arbiter dut (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .req_valid (req_valid),
    .req_addr  (req_addr),
`ifdef FRAME_ARB_LOCK_EN
    .req_lock  (req_lock),
`endif
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_pixel (rsp_pixel),
    .bram_addr (bram_addr),
    .bram_dout (bram_dout),
    .inflight  (inflight)
  );

  function automatic logic pix_of(input logic [AW-1:0] a);
    return ^(a ^ (a >> 3));
  endfunction

  // Frame memory: one register stage, the arbiter's output register is the second.
  always @(posedge clk_in) bram_dout <= pix_of(bram_addr);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Response monitor.
  always @(negedge clk_in) begin
    if (!rst_in) begin
      chk("rsp_onehot", 64'($onehot0(rsp_valid)), 64'd1);
      chk("inflight_max", 64'(inflight <= 2'd2), 64'd1);
      if (rsp_valid != 3'b000) begin
        if (exp_q.size() == 0) begin
          chk("rsp_unexpected", 64'(rsp_valid), 64'd0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("rsp_owner", 64'(rsp_valid), 64'(3'b001 << mon_e.idx));
          chk("rsp_pixel", 64'(rsp_pixel), 64'(mon_e.pix));
          chk("rsp_time", 64'(cyc), 64'(mon_e.due));
        end
      end else if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
        mon_e = exp_q.pop_front();
        chk("rsp_lost", 64'(rsp_valid), 64'(3'b001 << mon_e.idx));
      end
    end
  end

  task automatic step(input string name, input logic [2:0] v, input logic [2:0] lk,
                      input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                      input logic [AW-1:0] a2, input logic [2:0] exp_gnt);
    logic [AW-1:0] ea;
    exp_t e;
    @(posedge clk_in); #1;
    req_valid   = v;
    req_lock    = lk;
    req_addr[0] = a0;
    req_addr[1] = a1;
    req_addr[2] = a2;
    @(negedge clk_in);
    chk({name, "_ready"}, 64'(req_ready), 64'(exp_gnt));
    ea = '0;
    for (int i = 0; i < 3; i++) begin
      if (exp_gnt[i]) begin
        ea    = req_addr[i];
        e.idx = i;
        e.pix = pix_of(req_addr[i]);
        e.due = cyc + 2;
        exp_q.push_back(e);
      end
    end
    chk({name, "_addr"}, 64'(bram_addr), 64'(ea));
  endtask

  task automatic idle(input int n);
    repeat (n) step("idle", 3'b000, 3'b000, '0, '0, '0, 3'b000);
  endtask

  task automatic do_reset();
    @(posedge clk_in); #1;
    rst_in    = 1'b1;
    req_valid = 3'b000;
    req_lock  = 3'b000;
    repeat (2) @(posedge clk_in);
    #1;
    rst_in = 1'b0;
    exp_q.delete();
  endtask

  initial begin
    int cnt [3];
    logic [2:0] pend;
    logic [AW-1:0] paddr [3];
    int mptr, w, j;

    rst_in    = 1'b1;
    req_valid = 3'b000;
    req_lock  = 3'b000;
    req_addr  = '0;
    repeat (3) @(posedge clk_in);
    #1 rst_in = 1'b0;
    @(negedge clk_in);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_pixel", 64'(rsp_pixel), 64'd0);
    chk("rst_inflight", 64'(inflight), 64'd0);
    chk("rst_ready", 64'(req_ready), 64'd0);

    // 1: single requester, back-to-back
    step("t1_a", 3'b010, 3'b000, '0, 20'd0, '0, 3'b010);
    step("t1_b", 3'b010, 3'b000, '0, 20'd1, '0, 3'b010);
    step("t1_c", 3'b010, 3'b000, '0, 20'd2, '0, 3'b010);
    chk("t1_inflight", 64'(inflight), 64'd2);
    idle(3);
    chk("t1_drained", 64'(inflight), 64'd0);

    // 2: all valid, rotation 0,1,2,0,1,2
    do_reset();
    cnt = '{0, 0, 0};
    for (int k = 0; k < 6; k++) begin
      step("t2", 3'b111, 3'b000, AW'(1000 + cnt[0]), AW'(2000 + cnt[1]),
           AW'(3000 + cnt[2]), 3'b001 << (k % 3));
      cnt[k % 3]++;
      if (k >= 2) chk("t2_inflight", 64'(inflight), 64'd2);
    end
    idle(3);

    // 3: pointer at 0, only req 2 -> immediate; pointer back to 0
    step("t3_a", 3'b100, 3'b000, '0, '0, 20'd77, 3'b100);
    step("t3_b", 3'b101, 3'b000, 20'd55, '0, 20'd78, 3'b001);
    idle(3);

    // 4: reset right after two grants drops them
    step("t4_a", 3'b011, 3'b000, 20'd10, 20'd11, '0, 3'b010);
    step("t4_b", 3'b001, 3'b000, 20'd10, '0, '0, 3'b001);
    @(posedge clk_in); #1;
    rst_in    = 1'b1;
    req_valid = 3'b000;
    @(posedge clk_in); #1;
    rst_in = 1'b0;
    exp_q.delete();
    repeat (4) begin
      @(negedge clk_in);
      chk("t4_no_rsp", 64'(rsp_valid), 64'd0);
      chk("t4_inflight", 64'(inflight), 64'd0);
      @(posedge clk_in); #1;
    end
    step("t4_ptr0", 3'b111, 3'b000, 20'd20, 20'd21, 20'd22, 3'b001);
    idle(3);

`ifdef FRAME_ARB_LOCK_EN
    // 5: req 2 takes the lock, req 0 starves until release
    do_reset();
    step("t5_take", 3'b100, 3'b100, '0, '0, 20'd300, 3'b100);
    for (int k = 0; k < 10; k++) begin
      step("t5_held", {k[0], 2'b01}, 3'b100, 20'd50, '0, AW'(301 + k),
           k[0] ? 3'b100 : 3'b000);
    end
    step("t5_drop", 3'b001, 3'b000, 20'd50, '0, '0, 3'b000);
    step("t5_after", 3'b001, 3'b000, 20'd50, '0, '0, 3'b001);
    idle(3);
`endif

    // 6: random traffic against a round-robin reference
    do_reset();
    mptr = 0;
    pend = 3'b000;
    for (int i = 0; i < 3; i++) paddr[i] = '0;
    for (int c = 0; c < 10000; c++) begin
      @(posedge clk_in); #1;
      for (int i = 0; i < 3; i++) begin
        if (!pend[i] && ($urandom_range(0, 1) == 1)) begin
          pend[i]  = 1'b1;
          paddr[i] = AW'($urandom_range(0, FRAME_WIDTH * FRAME_HEIGHT - 1));
        end
      end
      req_valid = pend;
      req_lock  = 3'b000;
      for (int i = 0; i < 3; i++) req_addr[i] = paddr[i];
      w = -1;
      for (int k = 0; k < 3; k++) begin
        j = (mptr + k) % 3;
        if (w < 0 && pend[j]) w = j;
      end
      @(negedge clk_in);
      chk("t6_ready", 64'(req_ready), (w >= 0) ? 64'(3'b001 << w) : 64'd0);
      chk("t6_addr", 64'(bram_addr), (w >= 0) ? 64'(paddr[w]) : 64'd0);
      if (w >= 0) begin
        mon_e.idx = w;
        mon_e.pix = pix_of(paddr[w]);
        mon_e.due = cyc + 2;
        exp_q.push_back(mon_e);
        pend[w] = 1'b0;
        mptr    = (w + 1) % 3;
      end
    end
    idle(4);
    chk("t6_drain", 64'(exp_q.size()), 64'd0);
    chk("t6_inflight", 64'(inflight), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
